// File: rtl/md_pkg.sv
// rtl/md_pkg.sv - md_unit op codes and shared decode helpers.
// MD_UNIT_MADD_EN adds the multiply-accumulate family to the busy-op decode.
package md_pkg;

  typedef logic [3:0] md_op_t;

  localparam md_op_t OP_MULT  = 4'd0;
  localparam md_op_t OP_MULTU = 4'd1;
  localparam md_op_t OP_DIV   = 4'd2;
  localparam md_op_t OP_DIVU  = 4'd3;
  localparam md_op_t OP_MTHI  = 4'd4;
  localparam md_op_t OP_MTLO  = 4'd5;
  localparam md_op_t OP_MADD  = 4'd6;
  localparam md_op_t OP_MADDU = 4'd7;
  localparam md_op_t OP_MSUB  = 4'd8;
  localparam md_op_t OP_MSUBU = 4'd9;

  // Ops that occupy the unit for several cycles; also used by the stall unit.
  function automatic logic is_md_busy_op(input md_op_t op);
    case (op)
      OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: return 1'b1;
`ifdef MD_UNIT_MADD_EN
      OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic is_div_op(input md_op_t op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/md_calc.sv
// rtl/md_calc.sv - combinational multiply/divide datapath producing the {hi,lo} result.
// MD_UNIT_MADD_EN enables the accumulate/subtract variants.
module md_calc
  import md_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  md_op_t               op,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [2*WIDTH-1:0]   acc,
  output logic [2*WIDTH-1:0]   result
);

  localparam int W2 = 2 * WIDTH;

  logic [W2-1:0]    prod_s;
  logic [W2-1:0]    prod_u;
  logic             neg_a;
  logic             neg_b;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH-1:0] q_m;
  logic [WIDTH-1:0] r_m;
  logic [WIDTH-1:0] q_s;
  logic [WIDTH-1:0] r_s;
  logic [WIDTH-1:0] q_u;
  logic [WIDTH-1:0] r_u;
  logic             div_zero;

  assign prod_s = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
  assign prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

  // Signed divide on magnitudes; most-negative / -1 falls out as q=a, r=0.
  assign neg_a = a[WIDTH-1];
  assign neg_b = b[WIDTH-1];
  assign mag_a = neg_a ? (~a + 1'b1) : a;
  assign mag_b = neg_b ? (~b + 1'b1) : b;
  assign q_m   = mag_a / mag_b;
  assign r_m   = mag_a % mag_b;
  assign q_s   = (neg_a ^ neg_b) ? (~q_m + 1'b1) : q_m;
  assign r_s   = neg_a ? (~r_m + 1'b1) : r_m;
  assign q_u   = a / b;
  assign r_u   = a % b;
  assign div_zero = (b == '0);

  always_comb begin
    result = '0;
    case (op)
      OP_MULT:  result = prod_s;
      OP_MULTU: result = prod_u;
      OP_DIV:   result = div_zero ? {a, {WIDTH{1'b1}}} : {r_s, q_s};
      OP_DIVU:  result = div_zero ? {a, {WIDTH{1'b1}}} : {r_u, q_u};
`ifdef MD_UNIT_MADD_EN
      OP_MADD:  result = acc + prod_s;
      OP_MADDU: result = acc + prod_u;
      OP_MSUB:  result = acc - prod_s;
      OP_MSUBU: result = acc - prod_u;
`endif
      default:  result = '0;
    endcase
  end

`ifndef MD_UNIT_MADD_EN
  logic unused_acc;
  assign unused_acc = ^acc;
`endif

endmodule

// File: rtl/md_unit.sv
// rtl/md_unit.sv - E-stage multi-cycle multiply/divide unit with HI/LO and D-stage stall.
// MD_UNIT_MADD_EN enables MADD/MADDU/MSUB/MSUBU.
module md_unit
  import md_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  md_op_t           Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             MdUseD,
  output logic             Busy,
  output logic             Stall,
  output logic             Done,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] pend;
  logic [2*WIDTH-1:0] calc_res;

  md_calc #(.WIDTH(WIDTH)) u_calc (
    .op     (Op),
    .a      (A),
    .b      (B),
    .acc    ({Hi, Lo}),
    .result (calc_res)
  );

  assign Busy  = (cnt != '0);
  assign Stall = MdUseD & (Busy | (Start & is_md_busy_op(Op)));

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      cnt  <= '0;
      pend <= '0;
      Hi   <= '0;
      Lo   <= '0;
      Done <= 1'b0;
    end else begin
      Done <= 1'b0;
      if (cnt != '0) begin
        cnt <= cnt - CW'(1);
        if (cnt == CW'(1)) begin
          Hi   <= pend[2*WIDTH-1:WIDTH];
          Lo   <= pend[WIDTH-1:0];
          Done <= 1'b1;
        end
      end else if (Start) begin
        case (Op)
          OP_MTHI: Hi <= A;
          OP_MTLO: Lo <= A;
          default: begin
            if (is_md_busy_op(Op)) begin
              pend <= calc_res;
              cnt  <= is_div_op(Op) ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// tb/tb_md_unit.sv - scoreboard bench for md_unit with a behavioural arithmetic model.
// Honours MD_UNIT_MADD_EN when deciding what the accumulate ops should do.
module tb_md_unit;
  import md_pkg::*;

  localparam int W  = 32;
  localparam int MC = 5;
  localparam int DC = 10;

  logic          Clk = 1'b0;
  logic          Reset;
  logic          Start;
  logic [3:0]    Op;
  logic [W-1:0]  A;
  logic [W-1:0]  B;
  logic          MdUseD;
  logic          Busy;
  logic          Stall;
  logic          Done;
  logic [W-1:0]  Hi;
  logic [W-1:0]  Lo;

  int            n_chk  = 0;
  int            n_fail = 0;
  logic [63:0]   exp_q[$];
  logic [31:0]   model_hi;
  logic [31:0]   model_lo;
  logic [31:0]   prev_hi;
  logic [31:0]   prev_lo;

  always #5 Clk = ~Clk;

  md_unit #(.WIDTH(W), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .Clk    (Clk),
    .Reset  (Reset),
    .Start  (Start),
    .Op     (Op),
    .A      (A),
    .B      (B),
    .MdUseD (MdUseD),
    .Busy   (Busy),
    .Stall  (Stall),
    .Done   (Done),
    .Hi     (Hi),
    .Lo     (Lo)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit tb_multi(input logic [3:0] op);
    if (op <= 4'd3) return 1'b1;
`ifdef MD_UNIT_MADD_EN
    if (op >= 4'd6 && op <= 4'd9) return 1'b1;
`endif
    return 1'b0;
  endfunction

  function automatic logic [63:0] ref_result(input logic [3:0] op, input logic [31:0] a,
                                             input logic [31:0] b, input logic [63:0] acc);
    longint      sa, sb, ps, q, r;
    logic [63:0] ua, ub, pu, qu, ru;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ps = sa * sb;
    ua = {32'b0, a};
    ub = {32'b0, b};
    pu = ua * ub;
    case (op)
      4'd0: return ps;
      4'd1: return pu;
      4'd2: begin
        if (b == 32'd0) return {a, 32'hFFFFFFFF};
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'd0, a};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      4'd3: begin
        if (b == 32'd0) return {a, 32'hFFFFFFFF};
        qu = ua / ub;
        ru = ua % ub;
        return {ru[31:0], qu[31:0]};
      end
      4'd6: return acc + ps;
      4'd7: return acc + pu;
      4'd8: return acc - ps;
      4'd9: return acc - pu;
      default: return acc;
    endcase
  endfunction

  // Monitor: result scoreboard on Done, HI/LO stability while busy.
  always @(negedge Clk) begin
    if (Reset) begin
      if (Busy) chk("hold_hi_lo", {Hi, Lo}, {prev_hi, prev_lo});
      if (Done) begin
        if (exp_q.size() == 0) chk("unexpected_done", {63'd0, Done}, 64'd0);
        else chk("result", {Hi, Lo}, exp_q.pop_front());
      end
    end
    prev_hi = Hi;
    prev_lo = Lo;
  end

  task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] e;
    bit          multi;
    bit          use_d;
    int          lat;
    multi = tb_multi(op);
    lat   = (op == OP_DIV || op == OP_DIVU) ? DC : MC;
    e     = ref_result(op, a, b, {model_hi, model_lo});
    @(negedge Clk);
    use_d  = 1'($urandom_range(0, 1));
    Start  = 1'b1;
    Op     = op;
    A      = a;
    B      = b;
    MdUseD = use_d;
    #1 chk("stall_idle", {63'd0, Stall}, {63'd0, use_d & multi});
    @(posedge Clk);
    #1;
    Start  = 1'b0;
    MdUseD = 1'b0;
    if (multi) begin
      exp_q.push_back(e);
      {model_hi, model_lo} = e;
      for (int i = 0; i < lat; i++) begin
        @(negedge Clk);
        chk("busy_high", {63'd0, Busy}, 64'd1);
        chk("stall_busy", {63'd0, Stall}, {63'd0, MdUseD});
        chk("done_low", {63'd0, Done}, 64'd0);
        if (i == 1) begin
          Start  = 1'b1;
          Op     = OP_MULT;
          MdUseD = 1'b1;
        end else begin
          Start  = 1'($urandom_range(0, 1));
          Op     = 4'($urandom_range(0, 15));
          MdUseD = 1'($urandom_range(0, 1));
        end
        A = $urandom;
        B = $urandom;
      end
      @(negedge Clk);
      Start  = 1'b0;
      MdUseD = 1'b0;
      chk("busy_low", {63'd0, Busy}, 64'd0);
      chk("done_pulse", {63'd0, Done}, 64'd1);
      @(negedge Clk);
      chk("done_once", {63'd0, Done}, 64'd0);
    end else begin
      if (op == OP_MTHI) model_hi = a;
      else if (op == OP_MTLO) model_lo = a;
      chk("imm_busy", {63'd0, Busy}, 64'd0);
      chk("imm_hilo", {Hi, Lo}, {model_hi, model_lo});
    end
  endtask

  initial begin
    logic [3:0]  rop;
    logic [31:0] ra, rb;
    int          sel;
    Reset    = 1'b0;
    Start    = 1'b0;
    Op       = 4'd0;
    A        = '0;
    B        = '0;
    MdUseD   = 1'b0;
    model_hi = '0;
    model_lo = '0;
    repeat (2) @(negedge Clk);
    chk("rst_hilo", {Hi, Lo}, 64'd0);
    chk("rst_busy_done", {62'd0, Busy, Done}, 64'd0);
    Reset = 1'b1;

    do_op(OP_MULT, 32'hFFFFFFFD, 32'd7);
    chk("mult_dir", {Hi, Lo}, 64'hFFFFFFFF_FFFFFFEB);
    do_op(OP_DIVU, 32'd100, 32'd7);
    chk("divu_dir", {Hi, Lo}, {32'd2, 32'd14});
    do_op(OP_DIV, 32'hFFFFFFF9, 32'd2);
    chk("div_neg_dir", {Hi, Lo}, 64'hFFFFFFFF_FFFFFFFD);
    do_op(OP_DIV, 32'd5, 32'd0);
    chk("div_zero_dir", {Hi, Lo}, {32'd5, 32'hFFFFFFFF});
    do_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF);
    chk("div_ovf_dir", {Hi, Lo}, {32'd0, 32'h80000000});
    do_op(OP_MTHI, 32'h1234, 32'd0);
    chk("mthi_dir", {32'd0, Hi}, 64'h1234);

    do_op(OP_MTHI, 32'd0, 32'd0);
    do_op(OP_MTLO, 32'h10, 32'd0);
    do_op(OP_MADD, 32'd2, 32'd3);
`ifdef MD_UNIT_MADD_EN
    chk("madd_dir", {Hi, Lo}, 64'h16);
`else
    chk("madd_ignored", {Hi, Lo}, 64'h10);
`endif

    // Asynchronous reset in the middle of a divide.
    do_op(OP_MTHI, 32'hA5A5A5A5, 32'd0);
    do_op(OP_MTLO, 32'h5A5A5A5A, 32'd0);
    @(negedge Clk);
    Start = 1'b1;
    Op    = OP_DIV;
    A     = 32'd100;
    B     = 32'd7;
    @(posedge Clk);
    #1 Start = 1'b0;
    repeat (3) @(negedge Clk);
    #2 Reset = 1'b0;
    #1;
    chk("async_rst_hilo", {Hi, Lo}, 64'd0);
    chk("async_rst_busy_done", {62'd0, Busy, Done}, 64'd0);
    model_hi = '0;
    model_lo = '0;
    @(negedge Clk);
    Reset = 1'b1;
    repeat (15) begin
      @(negedge Clk);
      chk("post_rst_busy", {63'd0, Busy}, 64'd0);
    end

    for (int n = 0; n < 150; n++) begin
      rop = 4'($urandom_range(0, 15));
      ra  = $urandom;
      rb  = $urandom;
      sel = $urandom_range(0, 7);
      if (sel == 0) rb = 32'd0;
      else if (sel == 1) begin
        ra = 32'h80000000;
        rb = 32'hFFFFFFFF;
      end else if (sel == 2) rb = 32'($urandom_range(1, 9));
      do_op(rop, ra, rb);
    end

    repeat (3) @(negedge Clk);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Parametrised multi-cycle multiply/divide unit with HI/LO registers, sitting in the E stage of the 5-stage pipeline beside the ALU.
- Accepts one operation per start pulse and holds the results in Hi/Lo for mfhi/mflo forwarding.
- Raises Busy and a D-stage stall request while an operation is in flight, so the stall unit can hold any later md instruction.

Parameters:
- WIDTH, 32, operand and Hi/Lo width.
- MULT_CYCLES, 5, latency of all multiply-family ops; must be >= 1.
- DIV_CYCLES, 10, latency of div/divu; must be >= 1.

Ports:
- Clk  input  1  rising-edge clock.
- Reset  input  1  asynchronous, active-low reset.
- Start  input  1  E-stage md instruction valid this cycle.
- Op  input  4  operation code; values from md_pkg.
- A  input  WIDTH  forwarded rs value.
- B  input  WIDTH  forwarded rt value.
- MdUseD  input  1  D-stage instruction is any md op (mult/div/mthi/mtlo/mfhi/mflo).
- Busy  output  1  operation in flight.
- Stall  output  1  combinational: MdUseD & (Busy | (Start & Op is mult/div family)).
- Done  output  1  one-cycle pulse when Hi/Lo take a new multi-cycle result.
- Hi  output  WIDTH  HI register.
- Lo  output  WIDTH  LO register.

Behaviour:
- Reset low, asynchronously: Hi=0, Lo=0, Busy=0, Done=0, internal counter=0, pending results=0. Reset mid-operation discards the operation.
- Accept: Start=1 and Busy=0 at a rising edge.
- Start while Busy=1 is ignored; no state changes.
- Op codes outside the defined set are ignored; Busy never rises.
- MTHI/MTLO: Hi (resp. Lo) takes A at the accept edge. No Busy, no Done.
- MULT/MULTU/DIV/DIVU:
  - The 2*WIDTH result is computed at the accept edge and latched into pending registers.
  - The counter loads MULT_CYCLES or DIV_CYCLES.
  - Busy = (counter != 0), so Busy is high for exactly N cycles after the accept edge.
  - The counter decrements each edge. On the edge where it goes 1 -> 0: Hi/Lo take the pending values and Done=1 for the following cycle.
  - A new Start may be accepted on the cycle Busy is low.
- MULT: signed WIDTH x WIDTH -> 2*WIDTH; Hi = upper half, Lo = lower half. MULTU: same, unsigned.
- DIV: Lo = quotient truncated toward zero; Hi = remainder, carrying the sign of the dividend. DIVU: unsigned quotient and remainder.
- Divide by zero (B=0): Lo = all ones, Hi = A, both signed and unsigned.
- Signed overflow (A = most negative value, B = -1): Lo = A, Hi = 0.
- Hi/Lo never change while Busy=1.

Optional Feature:
- Macro MD_UNIT_MADD_EN.
- Defined: MADD/MADDU/MSUB/MSUBU are supported, with latency MULT_CYCLES.
  - MADD/MADDU: {Hi,Lo} + product (signed/unsigned); MSUB/MSUBU: {Hi,Lo} - product. Arithmetic is modulo 2^(2*WIDTH).
  - The accumulator is sampled from {Hi,Lo} at the accept edge.
- Undefined: these four codes are treated as undefined ops and ignored.

Decomposition:
- Package md_pkg holds the op-code constants: OP_MULT=0, OP_MULTU=1, OP_DIV=2, OP_DIVU=3, OP_MTHI=4, OP_MTLO=5, OP_MADD=6, OP_MADDU=7, OP_MSUB=8, OP_MSUBU=9.
- md_pkg also holds a function is_md_busy_op(op) used by both md_unit and the stall unit.
- One natural sub-module, md_calc: combinational, takes Op, A, B, {Hi,Lo}; produces the 2*WIDTH pending result, including the div-by-zero and overflow rules.
- md_unit keeps the counter, the registers and the handshake.

Test Plan:
- MULT A=0xFFFFFFFD, B=7, default parameters -> Busy high 5 cycles; then Hi=0xFFFFFFFF, Lo=0xFFFFFFEB; Done high exactly 1 cycle.
- DIVU 100/7 -> after 10 cycles Lo=14, Hi=2. DIV A=0xFFFFFFF9 (-7), B=2 -> Lo=0xFFFFFFFD, Hi=0xFFFFFFFF.
- DIV 5/0 -> Lo=0xFFFFFFFF, Hi=5. DIV 0x80000000 / 0xFFFFFFFF -> Lo=0x80000000, Hi=0.
- During a DIV: second Start MULT is ignored (Hi/Lo keep the DIV result); MdUseD=1 -> Stall=1. MTHI 0x1234 while idle -> Hi=0x1234 next edge, Busy stays 0.
- Reset asserted asynchronously in cycle 3 of a DIV -> Hi, Lo, Busy, Done go 0 immediately without a clock edge; no Done after release.
- With MD_UNIT_MADD_EN: Hi=0, Lo=0x10, MADD 2*3 -> after 5 cycles Lo=0x16, Hi=0. Without the macro, the same Op -> Busy stays 0 and Hi/Lo are unchanged.
